// File: rtl/pipe_pkg.sv
// Shared types for the rv32i pipeline-stage registers: stage occupancy states
// and the EX/MEM control bundle whose all-zero value has no architectural effect.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic [1:0] result_src;
    } ex_mem_ctrl_t;

    localparam int EX_MEM_CTRL_W = $bits(ex_mem_ctrl_t);

    function automatic logic [1:0] state_occupancy(input stage_state_t s);
        case (s)
            EMPTY:   return 2'd0;
            ONE:     return 2'd1;
            FULL:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, flush, bubble gating of the
// control field, optional 2-entry skid buffer and a saturating stall counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = EX_MEM_CTRL_W,
    parameter int DATA_W = 32,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    stage_state_t      state;
    stage_state_t      state_next;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              accept;
    logic              consume;
    logic              stall;

    assign accept  = in_valid && in_ready;
    assign consume = out_valid && out_ready;
    assign stall   = out_valid && !out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // With SKID=0 the ONE state never sees accept without consume, so FULL is unreachable.
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) state_next = ONE;
                end
                ONE: begin
                    if (accept && !consume) begin
                        state_next = (SKID != 0) ? FULL : ONE;
                    end else if (consume && !accept) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (consume) state_next = ONE;
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    // in_ready is held low during reset so nothing is accepted before the stage is clean.
    always_comb begin
        out_valid = (state != EMPTY);
        occupancy = state_occupancy(state);
        out_ctrl  = out_valid ? main_ctrl : '0;
        if (SKID != 0) begin
            in_ready = !reset && (state != FULL);
        end else begin
            in_ready = !reset && ((state == EMPTY) || out_ready);
        end
    end

    assign out_data = main_data;

    // MAIN always feeds the output; SKID only catches an entry accepted while MAIN is stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_ctrl <= '0;
            main_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else if (!flush) begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_ctrl <= in_ctrl;
                        main_data <= in_data;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        main_ctrl <= in_ctrl;
                        main_data <= in_data;
                    end else if (accept) begin
                        skid_ctrl <= in_ctrl;
                        skid_data <= in_data;
                    end
                end
                FULL: begin
                    if (consume) begin
                        main_ctrl <= skid_ctrl;
                        main_data <= skid_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall),
        .count (stall_cnt)
    );

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline-stage register for the rv32i pipeline; generalises the fixed Execute→Memory control register.
- Carries a control field and a data field between stages under a valid/ready handshake.
- Supports stall, flush and bubble insertion, with an optional 2-entry skid buffer that breaks the ready path.
- Saturating stall counter for performance monitoring.
- One instance per stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
- CTRL_W, 4, control-field width; bits must be zero-safe (0 = no architectural side effect, e.g. RegWrite, MemWrite, ResultSrc[1:0]).
- DATA_W, 32, data-field width (ALU result, write data, rd, PC+4 packed by the instantiator).
- SKID, 1, 1 = 2-entry skid buffer (registered in_ready); 0 = single entry (combinational in_ready).
- CNT_W, 16, stall-counter width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  discard all held entries (branch mispredict / jump)
- in_valid  in  1  upstream stage has a valid instruction
- in_ready  out  1  this stage accepts this cycle
- in_ctrl  in  CTRL_W  upstream control bits
- in_data  in  DATA_W  upstream data bits
- out_valid  out  1  downstream entry valid
- out_ready  in  1  downstream accepts this cycle
- out_ctrl  out  CTRL_W  control bits; forced to 0 when out_valid=0
- out_data  out  DATA_W  data bits; holds last value when invalid
- occupancy  out  2  entries held (0..2; max 1 when SKID=0)
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid && !out_ready

Behaviour:
- Reset (synchronous, active-high)
  - All entries invalid; out_valid=0; out_ctrl=0; out_data=0; occupancy=0; stall_cnt=0.
  - in_ready=0 during reset, 1 in the first cycle after reset.
- Handshakes
  - Input accepted when in_valid && in_ready.
  - Output consumed when out_valid && out_ready.
  - Latency: 1 cycle from acceptance to out_valid when the stage is empty.
- Bubble gating
  - out_ctrl = out_valid ? main_ctrl : 0. This gating is combinational.
  - Guarantees no RegWrite/MemWrite is issued from an invalid slot.
- SKID=1 state machine (registered, output drives from MAIN):
  - EMPTY (in_ready=1)
    - accept → ONE.
  - ONE (in_ready=1)
    - accept && !consume → FULL; input is written to SKID.
    - consume && !accept → EMPTY.
    - accept && consume → ONE; MAIN takes input.
    - otherwise hold.
  - FULL (in_ready=0)
    - consume → ONE; MAIN takes SKID contents.
    - otherwise hold.
  - in_ready = (state != FULL), registered; no combinational path from out_ready.
- SKID=0
  - Single MAIN entry.
  - in_ready = !main_valid || out_ready (combinational).
  - accept loads MAIN; consume without accept clears main_valid.
- Stall
  - While out_valid && !out_ready, MAIN ctrl/data are stable (no change).
- Flush
  - Next state is EMPTY; all valid bits cleared.
  - An input accepted in the same cycle is discarded.
  - Takes priority over accept, consume and stall.
  - stall_cnt is not cleared.
  - Next cycle: out_valid=0, out_ctrl=0.
- Reset vs flush
  - Reset has priority over flush.
  - Reset mid-stall discards everything.
- stall_cnt
  - Increments by 1 on each stall cycle.
  - Saturates at 2^CNT_W−1; never wraps.
  - Cleared only by reset.
- occupancy
  - EMPTY=0, ONE=1, FULL=2.
- Ordering
  - Strict FIFO; no entry is duplicated or dropped except by flush.

Decomposition:
- Shared package pipe_pkg:
  - typedef enum stage_state_t {EMPTY, ONE, FULL}.
  - typedef struct ex_mem_ctrl_t (RegWrite, MemWrite, ResultSrc[1:0]).
  - localparam EX_MEM_CTRL_W = $bits(ex_mem_ctrl_t).
- One sub-module, sat_counter (parameter CNT_W; inputs inc, reset), used for stall_cnt.
- The skid datapath stays inline.

Test Plan:
- Reset then stream: in_valid=1 each cycle, out_ready=1, ctrl=4'b1011, data=0x0000_0010..0x13 → out_valid rises 1 cycle after first accept; 4 entries out in order; occupancy stays 1; stall_cnt=0.
- Backpressure (SKID=1): out_ready=0 for 3 cycles while sending A=0xA, B=0xB, C=0xC.
  - in_ready falls after B; occupancy=2; C held upstream; stall_cnt=3; out_data=0xA stable.
  - Release out_ready → A, B, C emerge in order.
- Flush while FULL and in_valid=1 → next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; the flushed-cycle input never appears.
- Bubble: in_valid=0 with in_ctrl=4'b1111 → out_ctrl stays 4'b0000; out_data retains prior value.
- Saturation: CNT_W=3, hold out_valid=1, out_ready=0 for 10 cycles → stall_cnt reaches 7 and holds.
- SKID=0: out_ready toggling 1,0,1 with continuous input → in_ready mirrors out_ready while full; no loss or duplication across 8 entries.
- Reset asserted in FULL with flush=1 → all outputs return to reset values on the next edge.
